ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 36 +++
 rtl/ps2_sync_edge.sv | 42 ++++
 rtl/ps2_host_tx.sv | 193 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 host interface.
//   * ps2_tx_state_e : host-to-device transmit FSM states
//   * DEF_*_CYCLES   : default timing at a 50 MHz system clock
//   * *_CNT_W        : counter widths used by the transmitter
//   * KBD_*          : common keyboard command / response bytes
//   * odd_parity()   : parity bit that makes the 9-bit {parity,data} word odd
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_e;

  localparam int DEF_INHIBIT_CYCLES = 5000;    // 100 us at 50 MHz
  localparam int DEF_TIMEOUT_CYCLES = 750000;  // 15 ms at 50 MHz

  localparam int INHIBIT_CNT_W = 13;
  localparam int WDOG_CNT_W    = 20;
  localparam int BIT_IDX_W     = 4;

  localparam logic [7:0] KBD_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] KBD_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] KBD_CMD_RESET    = 8'hFF;
  localparam logic [7:0] KBD_RSP_ACK      = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge -- two-flop synchronizer plus falling-edge detector for one
// open-drain PS/2 line. Usable by both the host transmitter and a receiver.
//   clk       : system clock
//   reset     : asynchronous active-high reset (line assumed idle-high)
//   line_in   : raw, asynchronous line level
//   line_sync : synchronized line level
//   line_fall : one-cycle pulse when line_sync went 1 -> 0
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_sync,
  output logic line_fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = line_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign line_sync = sync_q;
  assign line_fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- sends one command byte from the host to a PS/2 device.
// Sequence: inhibit clock, request-to-send, shift 8 data bits LSB first,
// odd parity, release for stop, sample the device ACK, wait for bus idle.
//   clk, reset             : system clock, asynchronous active-high reset
//   tx_data/tx_valid       : byte to send, accepted when tx_ready is high
//   tx_ready / busy        : idle indication and its complement
//   ps2_clk_in/ps2_dat_in  : raw line levels
//   ps2_clk_oe/ps2_dat_oe  : 1 = pull line low, 0 = release
//   tx_done / tx_error     : one-cycle result pulses (ACK / NACK or timeout)
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy
);

  localparam logic [INHIBIT_CNT_W-1:0] INHIBIT_LAST = INHIBIT_CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [WDOG_CNT_W-1:0]    WDOG_LAST    = WDOG_CNT_W'(TIMEOUT_CYCLES - 1);

  logic clk_sync, clk_fall;
  logic dat_sync, dat_fall_unused;

  ps2_sync_edge u_clk_sync (
    .clk       (clk),
    .reset     (reset),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync),
    .line_fall (clk_fall)
  );

  ps2_sync_edge u_dat_sync (
    .clk       (clk),
    .reset     (reset),
    .line_in   (ps2_dat_in),
    .line_sync (dat_sync),
    .line_fall (dat_fall_unused)
  );

  ps2_tx_state_e            state_q, state_d;
  logic [7:0]               data_q, data_d;
  logic                     parity_q, parity_d;
  logic [INHIBIT_CNT_W-1:0] inhibit_cnt_q, inhibit_cnt_d;
  logic [BIT_IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [WDOG_CNT_W-1:0]    wdog_q, wdog_d;
  logic                     dat_oe_q, dat_oe_d;
  logic                     tx_done_q, tx_done_d;
  logic                     tx_error_q, tx_error_d;
  logic                     wdog_active, wdog_hit;

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    parity_d      = parity_q;
    inhibit_cnt_d = inhibit_cnt_q;
    bit_idx_d     = bit_idx_q;
    wdog_d        = wdog_q;
    dat_oe_d      = dat_oe_q;
    tx_done_d     = 1'b0;
    tx_error_d    = 1'b0;
    wdog_active   = (state_q inside {ST_DATA, ST_PARITY, ST_STOP, ST_ACK, ST_WAIT_IDLE});
    wdog_hit      = (wdog_q == WDOG_LAST);

    case (state_q)
      ST_IDLE: begin
        dat_oe_d = 1'b0;
        if (tx_valid) begin
          data_d        = tx_data;
          parity_d      = odd_parity(tx_data);
          inhibit_cnt_d = '0;
          bit_idx_d     = '0;
          state_d       = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inhibit_cnt_q == INHIBIT_LAST) begin
          dat_oe_d = 1'b1;  // request-to-send: data low while clock still held
          state_d  = ST_REQ;
        end else begin
          inhibit_cnt_d = inhibit_cnt_q + 13'd1;
        end
      end
      ST_REQ: begin
        // Releasing the clock with data still low is the start bit.
        wdog_d  = '0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (clk_fall) begin
          dat_oe_d  = ~data_q[bit_idx_q[2:0]];
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd7) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (clk_fall) begin
          dat_oe_d  = ~parity_q;
          bit_idx_d = bit_idx_q + 4'd1;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_fall) begin
          dat_oe_d  = 1'b0;
          bit_idx_d = bit_idx_q + 4'd1;
          state_d   = ST_ACK;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          bit_idx_d = bit_idx_q + 4'd1;
          if (dat_sync) begin
            tx_error_d = 1'b1;
          end else begin
            tx_done_d = 1'b1;
          end
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        dat_oe_d = 1'b0;
        if (clk_sync && dat_sync) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Watchdog overrides everything, including a clock edge in the same
    // cycle. WAIT_IDLE is only reached after a result pulse, so expiry
    // there just returns to IDLE silently.
    if (wdog_active) begin
      if (wdog_hit) begin
        state_d    = ST_IDLE;
        dat_oe_d   = 1'b0;
        bit_idx_d  = bit_idx_q;
        tx_done_d  = 1'b0;
        tx_error_d = (state_q != ST_WAIT_IDLE);
      end else begin
        wdog_d = wdog_q + 20'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      data_q        <= '0;
      parity_q      <= 1'b0;
      inhibit_cnt_q <= '0;
      bit_idx_q     <= '0;
      wdog_q        <= '0;
      dat_oe_q      <= 1'b0;
      tx_done_q     <= 1'b0;
      tx_error_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      parity_q      <= parity_d;
      inhibit_cnt_q <= inhibit_cnt_d;
      bit_idx_q     <= bit_idx_d;
      wdog_q        <= wdog_d;
      dat_oe_q      <= dat_oe_d;
      tx_done_q     <= tx_done_d;
      tx_error_q    <= tx_error_d;
    end
  end

  // Clock drive decodes straight from state so reset releases it at once.
  assign ps2_clk_oe = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
  assign ps2_dat_oe = dat_oe_q;
  assign tx_ready   = (state_q == ST_IDLE);
  assign busy       = ~tx_ready;
  assign tx_done    = tx_done_q;
  assign tx_error   = tx_error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- self-checking bench for ps2_host_tx with a behavioural
// PS/2 device on open-drain lines (wired-AND of host and device drive).
module tb_ps2_host_tx;

  localparam int INH_P = 5000;
  localparam int TMO_P = 3000;
  localparam int H     = 20;   // device half clock period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_dat_oe, tx_done, tx_error, busy;
  logic       dev_clk_rel = 1'b1;
  logic       dev_dat_rel = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;

  int n_cmp = 0;
  int n_bad = 0;

  assign ps2_clk_in = dev_clk_rel & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat_rel & ~ps2_dat_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH_P), .TIMEOUT_CYCLES(TMO_P)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .busy       (busy)
  );

  // Reference frame as the device should see it: {stop, parity, data LSB..MSB}.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    logic [9:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = ((b >> i) & 8'd1) != 0;
      ones += int'((b >> i) & 8'd1);
    end
    f[8] = (ones % 2 == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic start_byte(input logic [7:0] b, input bit hold, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2 * TMO_P; c++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1'b1; break; end
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  // mode 0: ACK, mode 1: NACK (data left high at edge 11), mode 2: silent
  task automatic device(input int mode, output logic [9:0] frame, output bit got_rts);
    frame   = '0;
    got_rts = 1'b0;
    if (mode != 2) begin
      for (int c = 0; c < INH_P + 200; c++) begin
        @(negedge clk);
        if (!ps2_clk_oe && ps2_dat_oe) begin got_rts = 1'b1; break; end
      end
      if (got_rts) begin
        for (int e = 1; e <= 11; e++) begin
          if (e == 11 && mode == 0) dev_dat_rel = 1'b0;
          repeat (H) @(negedge clk);
          dev_clk_rel = 1'b0;
          repeat (H) @(negedge clk);
          if (e <= 10) frame[e-1] = ps2_dat_in;
          dev_clk_rel = 1'b1;
        end
        repeat (H) @(negedge clk);
        dev_dat_rel = 1'b1;
      end
    end
  endtask

  task automatic monitor(input int budget, output int inh, output int req, output int done_n,
                         output int err_n, output int both_n, output int d2e, output bit to);
    int data_start, err_at;
    inh = 0; req = 0; done_n = 0; err_n = 0; both_n = 0; to = 1'b1;
    data_start = -1; err_at = -1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (ps2_clk_oe && !ps2_dat_oe) inh++;
      if (ps2_clk_oe && ps2_dat_oe) req++;
      if (data_start < 0 && req > 0 && !ps2_clk_oe && busy) data_start = cyc;
      if (tx_done) done_n++;
      if (tx_error) begin err_n++; if (err_at < 0) err_at = cyc; end
      if (tx_done && tx_error) both_n++;
      if (tx_ready) begin to = 1'b0; break; end
    end
    d2e = (err_at >= 0 && data_start >= 0) ? err_at - data_start : -1;
  endtask

  task automatic observe(input int mode, output logic [9:0] frame, output bit rts,
                         output int inh, output int req, output int dn, output int er,
                         output int bo, output int d2e, output bit to);
    fork
      device(mode, frame, rts);
      monitor(INH_P + TMO_P + 2000, inh, req, dn, er, bo, d2e, to);
    join
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", tx_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin n_bad++; $display("FAIL rst_oe: got %b want 00", {ps2_clk_oe, ps2_dat_oe}); end
    n_cmp++; if ({tx_done, tx_error} !== 2'b00) begin n_bad++; $display("FAIL rst_pulses: got %b want 00", {tx_done, tx_error}); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready: got %b want 1", tx_ready); end
    $display("reset: ready=%b busy=%b oe=%b%b", tx_ready, busy, ps2_clk_oe, ps2_dat_oe);
  endtask

  task automatic test_ack_ed();
    logic [9:0] fr; bit ok, rts, to; int inh, rq, dn, er, bo, d2e;
    start_byte(8'hED, 1'b0, ok);
    observe(0, fr, rts, inh, rq, dn, er, bo, d2e, to);
    $display("xfer 0x%02h ack: frame=%b inh=%0d req=%0d done=%0d err=%0d", 8'hED, fr, inh, rq, dn, er);
    n_cmp++; if (!ok || !rts || to) begin n_bad++; $display("FAIL ed_handshake: got ok=%b rts=%b to=%b want 1 1 0", ok, rts, to); end
    n_cmp++; if (inh !== INH_P) begin n_bad++; $display("FAIL ed_inhibit: got %0d want %0d", inh, INH_P); end
    n_cmp++; if (rq !== 1) begin n_bad++; $display("FAIL ed_req: got %0d want 1", rq); end
    n_cmp++; if (fr !== 10'b11_1110_1101) begin n_bad++; $display("FAIL ed_frame: got %b want %b", fr, 10'b11_1110_1101); end
    n_cmp++; if (dn !== 1 || er !== 0 || bo !== 0) begin n_bad++; $display("FAIL ed_result: got done=%0d err=%0d both=%0d want 1 0 0", dn, er, bo); end
  endtask

  task automatic test_nack_f4();
    logic [9:0] fr; bit ok, rts, to; int inh, rq, dn, er, bo, d2e;
    start_byte(8'hF4, 1'b0, ok);
    observe(1, fr, rts, inh, rq, dn, er, bo, d2e, to);
    $display("xfer 0x%02h nack: frame=%b done=%0d err=%0d", 8'hF4, fr, dn, er);
    n_cmp++; if (fr[8] !== 1'b0) begin n_bad++; $display("FAIL f4_parity: got %b want 0", fr[8]); end
    n_cmp++; if (fr !== model_frame(8'hF4)) begin n_bad++; $display("FAIL f4_frame: got %b want %b", fr, model_frame(8'hF4)); end
    n_cmp++; if (dn !== 0 || er !== 1 || bo !== 0 || to) begin n_bad++; $display("FAIL f4_result: got done=%0d err=%0d both=%0d to=%b want 0 1 0 0", dn, er, bo, to); end
  endtask

  task automatic test_timeout_ff();
    logic [9:0] fr; bit ok, rts, to; int inh, rq, dn, er, bo, d2e;
    start_byte(8'hFF, 1'b0, ok);
    observe(2, fr, rts, inh, rq, dn, er, bo, d2e, to);
    $display("xfer 0x%02h silent: data_to_error=%0d done=%0d err=%0d", 8'hFF, d2e, dn, er);
    n_cmp++; if (d2e !== TMO_P) begin n_bad++; $display("FAIL ff_timeout_latency: got %0d want %0d", d2e, TMO_P); end
    n_cmp++; if (dn !== 0 || er !== 1 || to) begin n_bad++; $display("FAIL ff_result: got done=%0d err=%0d to=%b want 0 1 0", dn, er, to); end
    n_cmp++; if ({ps2_clk_oe, ps2_dat_oe, tx_ready} !== 3'b001) begin n_bad++; $display("FAIL ff_idle: got oe=%b%b ready=%b want 00 1", ps2_clk_oe, ps2_dat_oe, tx_ready); end
  endtask

  task automatic test_reset_mid();
    bit ok, got; int pulses;
    start_byte(8'hED, 1'b0, ok);
    got = 1'b0;
    for (int c = 0; c < INH_P + 200; c++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_dat_oe) begin got = 1'b1; break; end
    end
    for (int e = 1; e <= 5; e++) begin
      repeat (H) @(negedge clk);
      dev_clk_rel = 1'b0;
      if (e < 5) begin repeat (H) @(negedge clk); dev_clk_rel = 1'b1; end
    end
    repeat (8) @(negedge clk);
    // bit 4 of 0xED is 0, so the host should be pulling data low here
    n_cmp++; if (ps2_dat_oe !== 1'b1 || !got) begin n_bad++; $display("FAIL mid_bit4: got dat_oe=%b rts=%b want 1 1", ps2_dat_oe, got); end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_cmp++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin n_bad++; $display("FAIL mid_release: got %b want 00", {ps2_clk_oe, ps2_dat_oe}); end
    n_cmp++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_idle: got ready=%b busy=%b want 1 0", tx_ready, busy); end
    pulses = 0;
    repeat (3) begin @(negedge clk); if (tx_done || tx_error) pulses++; end
    reset = 1'b0;
    dev_clk_rel = 1'b1;
    repeat (30) begin @(negedge clk); if (tx_done || tx_error) pulses++; end
    $display("xfer 0x%02h reset after edge 5: pulses=%0d ready=%b", 8'hED, pulses, tx_ready);
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL mid_pulses: got %0d want 0", pulses); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_after: got %b want 1", tx_ready); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] fr; bit ok, rts, to; int inh, rq, dn, er, bo, d2e;
    start_byte(8'hED, 1'b1, ok);
    tx_data = 8'h55;  // tx_valid stays high through the 0xED transfer
    observe(0, fr, rts, inh, rq, dn, er, bo, d2e, to);
    $display("xfer 0x%02h with pending 0x55: frame=%b done=%0d", 8'hED, fr, dn);
    n_cmp++; if (fr !== model_frame(8'hED)) begin n_bad++; $display("FAIL hold_first_frame: got %b want %b", fr, model_frame(8'hED)); end
    n_cmp++; if (dn !== 1 || to) begin n_bad++; $display("FAIL hold_first_done: got %0d to=%b want 1 0", dn, to); end
    @(posedge clk);
    #1 tx_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hold_accept: got busy=%b want 1", busy); end
    observe(0, fr, rts, inh, rq, dn, er, bo, d2e, to);
    $display("xfer 0x%02h after idle: frame=%b done=%0d", 8'h55, fr, dn);
    n_cmp++; if (fr !== model_frame(8'h55)) begin n_bad++; $display("FAIL hold_second_frame: got %b want %b", fr, model_frame(8'h55)); end
    n_cmp++; if (dn !== 1 || er !== 0) begin n_bad++; $display("FAIL hold_second_done: got done=%0d err=%0d want 1 0", dn, er); end
  endtask

  task automatic test_random();
    logic [9:0] fr; bit ok, rts, to; int inh, rq, dn, er, bo, d2e;
    logic [7:0] b; int mode;
    for (int n = 0; n < 3; n++) begin
      b    = 8'($urandom_range(0, 255));
      mode = int'($urandom_range(0, 1));
      start_byte(b, 1'b0, ok);
      observe(mode, fr, rts, inh, rq, dn, er, bo, d2e, to);
      $display("xfer 0x%02h mode=%0d: frame=%b done=%0d err=%0d", b, mode, fr, dn, er);
      n_cmp++; if (fr !== model_frame(b)) begin n_bad++; $display("FAIL rand_frame: got %b want %b", fr, model_frame(b)); end
      n_cmp++;
      if (dn !== (mode == 0 ? 1 : 0) || er !== (mode == 1 ? 1 : 0) || bo !== 0 || to) begin
        n_bad++; $display("FAIL rand_result: got done=%0d err=%0d both=%0d to=%b mode=%0d", dn, er, bo, to, mode);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ack_ed();
    test_nack_f4();
    test_timeout_ff();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
